ev2_sink_fifo: RTL and testbench
================================

EV2_SINK_FIFO -- requirements
Module: ev2_sink_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 9: log2 of the number of 32-bit FIFO entries.
REQ-002 Parameter SAT_COUNT, default 16'hFFFF: saturation value for count_o.
REQ-003 clk_i  input  1  the one clock; every port is synchronous to it.
REQ-004 reset_i  input  1  reset, asynchronous and active-high.
REQ-005 dat_i  input  16  ev2 event data word.
REQ-006 wr_i  input  1  ev2 write strobe; one word per cycle when high.
REQ-007 full_o  output  1  ev2 full flag.
REQ-008 count_o  output  16  free space in 16-bit words, saturated at SAT_COUNT.
REQ-009 rst_i  input  1  ev2 reset request, level.
REQ-010 rst_ack_o  output  1  ev2 reset acknowledge, level.
REQ-011 flush_i  input  1  one-cycle pulse; pushes a pending odd half-word.
REQ-012 out_dat_o  output  32  packed output word; first ev2 word in [15:0].
REQ-013 out_odd_o  output  1  out_dat_o[31:16] is padding (0x0000).
REQ-014 out_valid_o  output  1  output word available (first-word-fall-through).
REQ-015 out_ready_i  input  1  consumer accepts the word when valid and ready are both high.

Function
REQ-016 Packing: the 1st accepted word goes to a holding register (hold_v=1); the 2nd pushes {dat_i, hold} with odd=0 into the FIFO and clears hold_v.
REQ-017 A write is accepted only when wr_i=1, full_o=0 and the state is RUN; any other write is dropped.
REQ-018 Free space: free = 2*(2^DEPTH_LOG2 - entries) - hold_v.
REQ-019 count_o = min(free, SAT_COUNT), registered, updated one cycle after each push or pop.
REQ-020 full_o = 1 when free==0 or state != RUN.
REQ-021 flush_i with hold_v=1 and no write: push {16'h0000, hold} with odd=1; clear hold_v.
REQ-022 flush_i with hold_v=0 and no write: no action.
REQ-023 flush_i with wr_i accepted and hold_v=0: push {16'h0000, dat_i} with odd=1.
REQ-024 flush_i with wr_i accepted and hold_v=1: push the normal pair only.
REQ-025 Output handshake: out_valid_o rises 2 cycles after a push into an empty FIFO.
REQ-026 Output data: out_dat_o and out_odd_o stay stable while valid=1 and ready=0.
REQ-027 Full-boundary push/pop: a push and a pop in the same cycle at the full boundary both succeed; entries is unchanged.
REQ-028 Pointer wrap: pointers wrap modulo 2^DEPTH_LOG2 with no loss of data.
REQ-029 States and transitions:
- RUN -> FLUSH when rst_i=1.
- FLUSH (1 cycle): clears pointers, hold_v and out_valid_o; then goes to ACK.
- ACK: rst_ack_o=1; stays while rst_i=1; returns to RUN when rst_i=0, with rst_ack_o=0 in that same cycle.
REQ-030 rst_i asserted mid-packet discards the partial word and all buffered entries.

Reset
REQ-031 reset_i=1 forces state RUN, empty FIFO and hold_v=0.
REQ-032 Output values under reset_i: full_o=0, count_o=min(2^(DEPTH_LOG2+1), SAT_COUNT), rst_ack_o=0, out_valid_o=0, out_dat_o=0, out_odd_o=0.
REQ-033 RAM contents are not reset.

Configuration
REQ-034 With EV2_SINK_OVERFLOW_CNT_EN defined: output port ovf_cnt_o (16-bit) counts writes dropped with wr_i=1 while full_o=1; it saturates at 0xFFFF and clears on reset_i or in FLUSH.
REQ-035 Without EV2_SINK_OVERFLOW_CNT_EN: port ovf_cnt_o and its counter are absent; behaviour is otherwise identical.

Structure
REQ-036 Package ev2_sink_pkg holds: the state enum (RUN, FLUSH, ACK), the 33-bit entry width constant, and the pad value 16'h0000.
REQ-037 Sub-module ev2_sink_ram: simple dual-port RAM, 33 bits x 2^DEPTH_LOG2, registered read.

Verification
REQ-038 Scenario 1: write 0x1111, 0x2222 with out_ready_i=1 -> out_dat_o=0x22221111 and out_odd_o=0, valid 2 cycles after the 2nd write; count_o returns to 1024.
REQ-039 Scenario 2: write 0xAAAA, then flush_i -> out_dat_o=0x0000AAAA with out_odd_o=1.
REQ-040 Scenario 3: DEPTH_LOG2=2, out_ready_i=0, 9 writes -> full_o after the 8th write; the 9th is dropped; with the macro defined, ovf_cnt_o=1.
REQ-041 Scenario 4: 3 entries buffered and hold_v=1, assert rst_i -> rst_ack_o high 2 cycles later; deassert rst_i -> out_valid_o=0, count_o=1024.
REQ-042 Scenario 5: 4096 streaming writes at full rate with random out_ready_i -> all 2048 words arrive in order across pointer wrap.
REQ-043 Scenario 6: reset_i pulsed mid-stream -> all outputs at their reset values immediately (asynchronously).

Source files
------------

// File: rtl/ev2_sink_pkg.sv
// ev2_sink_pkg: shared types and constants for the ev2 sink FIFO.
// Entries are 33 bits wide: {odd, high half-word, low half-word}.
package ev2_sink_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int          ENTRY_W = 33;
  localparam logic [15:0] PAD     = 16'h0000;

endpackage

// File: rtl/ev2_sink_ram.sv
// ev2_sink_ram: simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module ev2_sink_ram
  import ev2_sink_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [2**ADDR_W];

  // Storage array and read register; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ev2_sink_fifo.sv
// ev2_sink_fifo: packs pairs of 16-bit ev2 words into 32-bit entries and buffers
// them in a first-word-fall-through FIFO, with an ev2 reset request/acknowledge.
// Optional feature: define EV2_SINK_OVERFLOW_CNT_EN to add the ovf_cnt_o counter
// of writes dropped while full_o is high.
module ev2_sink_fifo
  import ev2_sink_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [15:0] SAT_COUNT  = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] dat_i,
  input  logic        wr_i,
  output logic        full_o,
  output logic [15:0] count_o,
  input  logic        rst_i,
  output logic        rst_ack_o,
  input  logic        flush_i,
  output logic [31:0] out_dat_o,
  output logic        out_odd_o,
  output logic        out_valid_o,
`ifdef EV2_SINK_OVERFLOW_CNT_EN
  output logic [15:0] ovf_cnt_o,
`endif
  input  logic        out_ready_i
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0]       MAX_FREE  = 32'(DEPTH << 1);
  localparam logic [15:0]       COUNT_RST = (MAX_FREE > 32'(SAT_COUNT)) ? SAT_COUNT : MAX_FREE[15:0];
  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  state_t               state;
  logic [DEPTH_LOG2:0]  wr_ptr;
  logic [DEPTH_LOG2:0]  rd_ptr;
  logic [DEPTH_LOG2:0]  entries;
  logic                 hold_v;
  logic [15:0]          hold;
  logic                 q_valid;
  logic [ENTRY_W-1:0]   ram_q;
  logic [ENTRY_W-1:0]   push_data;
  logic [31:0]          free_words;
  logic                 run;
  logic                 wr_acc;
  logic                 push;
  logic                 pop;
  logic                 q_move;
  logic                 rd_en;

  // entries counts every packed word held anywhere (RAM, read register, output
  // register), so full_o stays honest while the consumer is stalled
  assign run        = (state == RUN);
  assign free_words = ((32'(DEPTH) - 32'(entries)) << 1) - 32'(hold_v);
  assign full_o     = (free_words == 32'd0) || !run;
  assign wr_acc     = wr_i && !full_o;
  assign pop        = out_valid_o && out_ready_i;
  assign q_move     = q_valid && (!out_valid_o || out_ready_i);
  assign rd_en      = run && (wr_ptr != rd_ptr) && (!q_valid || q_move);

  // Decide what, if anything, gets pushed this cycle: a full pair, or a padded odd word
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (wr_acc && hold_v) begin
      push      = 1'b1;
      push_data = {1'b0, dat_i, hold};
    end else if (wr_acc && flush_i) begin
      push      = 1'b1;
      push_data = {1'b1, PAD, dat_i};
    end else if (!wr_acc && flush_i && hold_v && run) begin
      push      = 1'b1;
      push_data = {1'b1, PAD, hold};
    end
  end

  ev2_sink_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk_i),
    .we    (push),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (push_data),
    .re    (rd_en),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (ram_q)
  );

  // ev2 reset handshake: one FLUSH cycle wipes the buffer, ACK holds until rst_i drops
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= RUN;
      rst_ack_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (rst_i) state <= FLUSH;
        end
        FLUSH: begin
          state     <= ACK;
          rst_ack_o <= 1'b1;
        end
        ACK: begin
          if (!rst_i) begin
            state     <= RUN;
            rst_ack_o <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          rst_ack_o <= 1'b0;
        end
      endcase
    end
  end

  // Packing, pointers, prefetch into the RAM read register and the output register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entries     <= '0;
      hold_v      <= 1'b0;
      hold        <= '0;
      q_valid     <= 1'b0;
      out_valid_o <= 1'b0;
      out_dat_o   <= '0;
      out_odd_o   <= 1'b0;
    end else if (state == FLUSH) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entries     <= '0;
      hold_v      <= 1'b0;
      q_valid     <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) entries <= entries + PTR_ONE;
      else if (!push && pop) entries <= entries - PTR_ONE;
      if (wr_acc && !hold_v && !flush_i) begin
        hold   <= dat_i;
        hold_v <= 1'b1;
      end else if (push) begin
        hold_v <= 1'b0;
      end
      if (rd_en) q_valid <= 1'b1;
      else if (q_move) q_valid <= 1'b0;
      if (q_move) begin
        out_valid_o <= 1'b1;
        out_dat_o   <= ram_q[31:0];
        out_odd_o   <= ram_q[32];
      end else if (pop) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  // Free-space report, saturated and registered so it trails the buffer by one cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_o <= COUNT_RST;
    else count_o <= (free_words > 32'(SAT_COUNT)) ? SAT_COUNT : free_words[15:0];
  end

`ifdef EV2_SINK_OVERFLOW_CNT_EN
  // Saturating count of writes that arrived while full_o was high
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ovf_cnt_o <= '0;
    else if (state == FLUSH) ovf_cnt_o <= '0;
    else if (wr_i && full_o && (ovf_cnt_o != 16'hFFFF)) ovf_cnt_o <= ovf_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ev2_sink_fifo.sv
// tb_ev2_sink_fifo: directed scenarios against ev2_sink_fifo (DEPTH_LOG2=9) with a
// packing/free-space model and a scoreboard queue of expected 33-bit entries.
// Compiles with or without EV2_SINK_OVERFLOW_CNT_EN.
module tb_ev2_sink_fifo;

  localparam int          DEPTH     = 512;
  localparam logic [15:0] SAT_COUNT = 16'hFFFF;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] dat_i;
  logic        wr_i;
  logic        full_o;
  logic [15:0] count_o;
  logic        rst_i;
  logic        rst_ack_o;
  logic        flush_i;
  logic [31:0] out_dat_o;
  logic        out_odd_o;
  logic        out_valid_o;
  logic        out_ready_i;
`ifdef EV2_SINK_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_o;
`endif

  ev2_sink_fifo #(
    .DEPTH_LOG2 (9),
    .SAT_COUNT  (SAT_COUNT)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .dat_i       (dat_i),
    .wr_i        (wr_i),
    .full_o      (full_o),
    .count_o     (count_o),
    .rst_i       (rst_i),
    .rst_ack_o   (rst_ack_o),
    .flush_i     (flush_i),
    .out_dat_o   (out_dat_o),
    .out_odd_o   (out_odd_o),
    .out_valid_o (out_valid_o),
`ifdef EV2_SINK_OVERFLOW_CNT_EN
    .ovf_cnt_o   (ovf_cnt_o),
`endif
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int          testCount = 0;
  int          failCount = 0;
  logic [32:0] sbQueue[$];
  logic [32:0] expWord;
  int          mEntries;
  logic        mHoldV;
  logic [15:0] mHold;
  logic        mRun;
  int          mOvf;
  int          rxCount = 0;
  int          rxStart;
  logic        randReady;

  task automatic checkOutput(input string tag, input logic [32:0] observed, input logic [32:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelCount();
    int freeM;
    freeM = 2 * (DEPTH - mEntries) - int'(mHoldV);
    return (freeM > int'(SAT_COUNT)) ? SAT_COUNT : 16'(freeM);
  endfunction

  task automatic modelClear();
    sbQueue.delete();
    mEntries = 0;
    mHoldV   = 1'b0;
    mOvf     = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      if (randReady) out_ready_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Drive one cycle of ev2 input and record what the model expects to be pushed
  task automatic applyStimulus(input logic wr, input logic [15:0] dat, input logic flush);
    int   freeM;
    logic fullM;
    logic acc;
    freeM = 2 * (DEPTH - mEntries) - int'(mHoldV);
    fullM = (freeM == 0) || !mRun;
    if (wr) checkOutput("full_o", 33'(full_o), 33'(fullM));
    acc = wr && !fullM;
    if (wr && fullM && mOvf < 65535) mOvf++;
    if (acc && mHoldV) begin
      sbQueue.push_back({1'b0, dat, mHold});
      mEntries++;
      mHoldV = 1'b0;
    end else if (acc && flush) begin
      sbQueue.push_back({1'b1, 16'h0000, dat});
      mEntries++;
    end else if (acc) begin
      mHold  = dat;
      mHoldV = 1'b1;
    end else if (flush && mHoldV && mRun) begin
      sbQueue.push_back({1'b1, 16'h0000, mHold});
      mEntries++;
      mHoldV = 1'b0;
    end
    wr_i    = wr;
    dat_i   = dat;
    flush_i = flush;
    tick(1);
    wr_i    = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < maxCycles) begin
      tick(1);
      n++;
    end
    checkOutput("drain_empty", 33'(sbQueue.size()), 33'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_full"}, 33'(full_o), 33'd0);
    checkOutput({tag, "_count"}, 33'(count_o), 33'd1024);
    checkOutput({tag, "_ack"}, 33'(rst_ack_o), 33'd0);
    checkOutput({tag, "_valid"}, 33'(out_valid_o), 33'd0);
    checkOutput({tag, "_dat"}, 33'(out_dat_o), 33'd0);
    checkOutput({tag, "_odd"}, 33'(out_odd_o), 33'd0);
  endtask

  // Scoreboard: each output handshake pops the oldest expected entry
  always @(negedge clk_i) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      checkOutput("sb_has_word", 33'(sbQueue.size() != 0), 33'd1);
      if (sbQueue.size() != 0) begin
        expWord = sbQueue.pop_front();
        checkOutput("out_word", {out_odd_o, out_dat_o}, expWord);
      end
      mEntries--;
      rxCount++;
    end
  end

  initial begin
    reset_i     = 1'b0;
    dat_i       = '0;
    wr_i        = 1'b0;
    rst_i       = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    randReady   = 1'b0;
    mRun        = 1'b1;
    mHold       = '0;
    modelClear();
    #1 reset_i = 1'b1;
    #2 checkResetValues("por");
    tick(2);
    reset_i = 1'b0;
    tick(1);

    // Scenario 1: one packed pair, valid two cycles after the pushing write
    out_ready_i = 1'b1;
    applyStimulus(1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0);
    checkOutput("s1_valid_e1", 33'(out_valid_o), 33'd0);
    tick(1);
    checkOutput("s1_valid_e2", 33'(out_valid_o), 33'd0);
    tick(1);
    checkOutput("s1_valid_e3", 33'(out_valid_o), 33'd1);
    checkOutput("s1_word", {out_odd_o, out_dat_o}, 33'h0_2222_1111);
    waitDrain(20);
    tick(2);
    checkOutput("s1_count", 33'(count_o), 33'd1024);

    // Scenario 2 and flush corner cases
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick(2);
    checkOutput("s2_valid", 33'(out_valid_o), 33'd1);
    checkOutput("s2_word", {out_odd_o, out_dat_o}, 33'h1_0000_AAAA);
    waitDrain(20);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    tick(3);
    checkOutput("flush_idle_valid", 33'(out_valid_o), 33'd0);
    checkOutput("flush_idle_count", 33'(count_o), 33'd1024);
    applyStimulus(1'b1, 16'h5555, 1'b1);
    applyStimulus(1'b1, 16'h6666, 1'b0);
    applyStimulus(1'b1, 16'h7777, 1'b1);
    waitDrain(20);
    tick(2);
    checkOutput("flush_pair_count", 33'(count_o), 33'd1024);

    // Scenario 3: fill to full with the consumer stalled, then the full boundary
    out_ready_i = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b1, 16'(i * 3 + 1), 1'b0);
    checkOutput("s3_full", 33'(full_o), 33'd1);
    applyStimulus(1'b1, 16'hDEAD, 1'b0);
    tick(1);
    checkOutput("s3_count_zero", 33'(count_o), 33'd0);
`ifdef EV2_SINK_OVERFLOW_CNT_EN
    checkOutput("s3_ovf", 33'(ovf_cnt_o), 33'(mOvf));
`endif
    out_ready_i = 1'b1;
    tick(1);
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 16'hA5A5, 1'b0);
    out_ready_i = 1'b1;
    applyStimulus(1'b1, 16'h5A5A, 1'b0);
    out_ready_i = 1'b0;
    tick(2);
    checkOutput("s3_boundary_count", 33'(count_o), 33'd2);
    checkOutput("s3_boundary_full", 33'(full_o), 33'd0);
    applyStimulus(1'b1, 16'hC001, 1'b0);
    applyStimulus(1'b1, 16'hC002, 1'b0);
    checkOutput("s3_full_again", 33'(full_o), 33'd1);
    out_ready_i = 1'b1;
    waitDrain(2000);
    tick(2);
    checkOutput("s3_count_back", 33'(count_o), 33'd1024);

    // Scenario 4: ev2 reset request with 3 entries buffered and a half-word held
    out_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'(16'h4000 + i), 1'b0);
    tick(2);
    checkOutput("s4_count_pre", 33'(count_o), 33'(modelCount()));
    checkOutput("s4_valid_pre", 33'(out_valid_o), 33'd1);
    rst_i = 1'b1;
    tick(1);
    mRun = 1'b0;
    checkOutput("s4_ack_e1", 33'(rst_ack_o), 33'd0);
    checkOutput("s4_full_flush", 33'(full_o), 33'd1);
    tick(1);
    modelClear();
    checkOutput("s4_ack_e2", 33'(rst_ack_o), 33'd1);
    checkOutput("s4_valid_ack", 33'(out_valid_o), 33'd0);
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    checkOutput("s4_ack_held", 33'(rst_ack_o), 33'd1);
`ifdef EV2_SINK_OVERFLOW_CNT_EN
    checkOutput("s4_ovf", 33'(ovf_cnt_o), 33'(mOvf));
`endif
    rst_i = 1'b0;
    tick(1);
    mRun = 1'b1;
    checkOutput("s4_ack_low", 33'(rst_ack_o), 33'd0);
    checkOutput("s4_valid_post", 33'(out_valid_o), 33'd0);
    checkOutput("s4_full_post", 33'(full_o), 33'd0);
    tick(1);
    checkOutput("s4_count_post", 33'(count_o), 33'd1024);
    out_ready_i = 1'b1;
    applyStimulus(1'b1, 16'h3333, 1'b0);
    applyStimulus(1'b1, 16'h4444, 1'b0);
    waitDrain(20);

    // Scenario 5: 4096 writes at full rate with a randomly stalling consumer
    rxStart   = rxCount;
    randReady = 1'b1;
    for (int i = 0; i < 4096; i++) applyStimulus(1'b1, 16'(i * 7 + 3), 1'b0);
    waitDrain(6000);
    randReady   = 1'b0;
    out_ready_i = 1'b1;
    checkOutput("s5_rx_words", 33'(rxCount - rxStart), 33'd2048);
    tick(2);
    checkOutput("s5_count", 33'(count_o), 33'd1024);

    // Scenario 6: asynchronous reset mid-stream
    out_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'(16'h6000 + i), 1'b0);
    tick(2);
    checkOutput("s6_valid_pre", 33'(out_valid_o), 33'd1);
    #1 reset_i = 1'b1;
    #1 checkResetValues("s6");
    modelClear();
    #1 reset_i = 1'b0;
    tick(1);
    out_ready_i = 1'b1;
    applyStimulus(1'b1, 16'h8888, 1'b0);
    applyStimulus(1'b1, 16'h9999, 1'b0);
    waitDrain(20);
    tick(2);
    checkOutput("s6_count_post", 33'(count_o), 33'd1024);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
